hwag_spi_frame_master: RTL and testbench
========================================

Name: hwag_spi_frame_master

Overview:
- SPI master that builds and serialises the HWAG command frame [CMD8]:[ADDR8]:[DATA32]:[CRC8] toward the HWAG SPI slave.
- Computes CRC8 on the fly and appends it as the final byte.
- Used as the host-side driver in the FPGA test harness and on boards where a local controller programs the HWAG settings.
- Single clock domain; SCK is generated by dividing clk.

Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period. Legal range is 1 or more.
- CRC_POLY, 8'h07: CRC8 generator polynomial.
- CRC_INIT, 8'h00: CRC register value at frame start.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle request to send a frame; sampled only when busy=0.
- cmd  input  8  frame byte 0, latched at an accepted start.
- addr  input  8  frame byte 1, latched at an accepted start.
- data  input  32  frame bytes 2..5, latched at an accepted start.
- busy  output  1  high from the cycle after an accepted start until the end of GAP.
- done  output  1  one-cycle pulse in the cycle spi_ss returns high.
- tx_crc  output  8  CRC of the last sent frame; valid from done until the next accepted start.
- spi_sck  output  1  serial clock; idles low.
- spi_mosi  output  1  serial data out, MSB first.
- spi_miso  input  1  serial data in; used only under the optional feature.
- spi_ss  output  1  slave select, active-low; idles high.
- rx_frame  output  56  received bytes, byte 0 in [7:0] … byte 6 in [55:48].
- rx_crc_ok  output  1  receive CRC check result.

Behaviour:
- Reset (rst sampled high): all outputs go to idle values on the next edge.
  - busy=0, done=0, tx_crc=0, spi_sck=0, spi_mosi=0, spi_ss=1, rx_frame=0, rx_crc_ok=0.
  - State returns to IDLE.
  - Reset mid-frame aborts the frame immediately; no done pulse is generated.
- Frame byte order on the wire: cmd, addr, data[7:0], data[15:8], data[23:16], data[31:24], crc. Each byte is sent MSB first.
- SPI mode 0:
  - spi_mosi changes only while spi_sck is low: at SETUP entry and at each falling edge.
  - The slave samples on the rising edge.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE: start=1 latches the frame and loads the CRC register with CRC_INIT. Next cycle: SETUP, spi_ss=0, busy=1, spi_mosi = cmd[7].
  - SETUP: lasts CLK_DIV cycles, SCK low, then goes to SHIFT.
  - SHIFT: 56 bits, each 2*CLK_DIV cycles; SCK is low for the first half and high for the second half. After bit 55's high half: SCK low, go to HOLD.
  - HOLD: lasts CLK_DIV cycles, then spi_ss=1, done=1 for one cycle, tx_crc updated, go to GAP.
  - GAP: lasts CLK_DIV cycles with busy=1, then IDLE with busy=0.
- Total busy time is 115*CLK_DIV cycles (460 at the default).
- start while busy=1 is ignored, with no queuing. start in the first cycle busy=0 is accepted.
- The latched frame is immune to input changes after acceptance.
- CRC, serial per transmitted bit b over bits 0..47:
  - fb = crc[7] ^ b; crc = {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - Bits 48..55 are crc[7:0] frozen after bit 47, sent MSB first.
- Counters:
  - Divider counter: width $clog2(CLK_DIV)+1.
  - Bit counter: 6 bits, 0..55. No wrap beyond 55.

Optional Feature:
- Macro: HWAG_SPI_MASTER_MISO_CAPTURE_EN.
- Defined:
  - spi_miso is sampled on each SCK rising edge into a 56-bit shift register. The data is then placed into byte lanes, MSB first per byte.
  - A parallel serial CRC is computed over received bits 0..47.
  - At done, rx_frame is updated and rx_crc_ok = (received byte 6 == computed CRC).
  - Both outputs hold until the next done or reset.
- Undefined: no MISO logic is present. rx_frame=0 and rx_crc_ok=0 constantly, and spi_miso is unused.

Test Plan:
- Reset: hold rst 3 cycles mid-idle → busy=0, spi_ss=1, spi_sck=0, spi_mosi=0, done=0.
- cmd=8'h00, addr=8'h00, data=32'h01000000, start pulse:
  - Wire bytes 00 00 00 00 00 01 07.
  - Exactly 56 SCK rising edges.
  - busy high for 460 cycles, done one cycle, tx_crc=8'h07.
- All-zero frame → spi_mosi low for the whole frame, tx_crc=8'h00, done after 456 cycles of spi_ss low.
- start held high continuously with CLK_DIV=4:
  - Frames are back-to-back with spi_ss high exactly 5 cycles between them.
  - A start pulse mid-frame with changed data does not alter the frame in flight.
- rst asserted at the 20th SCK rising edge:
  - Next cycle spi_ss=1, spi_sck=0, busy=0, no done pulse.
  - The following frame (cmd=8'hA5) is bit-exact with the reference model.
- Feature on, spi_miso tied to spi_mosi, frame 00 00 00 00 00 01 → rx_frame=56'h07_01_00_00_00_00_00 and rx_crc_ok=1. Flipping one MISO bit gives rx_crc_ok=0.

Source files
------------

// File: rtl/hwag_spi_frame_master.sv
// rtl/hwag_spi_frame_master.sv - HWAG command-frame SPI master (mode 0, CRC8 appended)
// Sends [CMD8]:[ADDR8]:[DATA32 little-endian bytes]:[CRC8], each byte MSB first.
// Optional MISO capture is compiled in with `define HWAG_SPI_MASTER_MISO_CAPTURE_EN.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, cmd/addr/data frame request and payload (latched when accepted)
//   busy, done, tx_crc   frame status and CRC of the last sent frame
//   spi_sck/mosi/miso/ss SPI pins (sck idles low, ss active-low)
//   rx_frame, rx_crc_ok  captured MISO frame and its CRC check (feature only)
module hwag_spi_frame_master #(
    parameter int         CLK_DIV  = 4,
    parameter logic [7:0] CRC_POLY = 8'h07,
    parameter logic [7:0] CRC_INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [7:0]  addr,
    input  logic [31:0] data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  tx_crc,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_ss,
    output logic [55:0] rx_frame,
    output logic        rx_crc_ok
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam int            DW       = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [2:0]    state;
    logic [DW-1:0] div_cnt;
    logic [5:0]    bit_cnt;
    logic [47:0]   tx_sreg;
    logic [7:0]    crc;
    logic          div_end;
    logic          sck_rise;
    logic          hold_end;
    logic [47:0]   tx_shifted;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    assign div_end  = (div_cnt == DIV_LAST);
    assign sck_rise = (state == S_SHIFT) && div_end && !spi_sck;
    assign hold_end = (state == S_HOLD) && div_end;

    // After bit 47 the payload is exhausted; the frozen CRC becomes the last byte.
    assign tx_shifted = (bit_cnt == 6'd47) ? {crc, 40'h0} : {tx_sreg[46:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sreg  <= '0;
            crc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_crc   <= '0;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_ss   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    div_cnt <= '0;
                    if (start) begin
                        tx_sreg  <= {cmd, addr, data[7:0], data[15:8], data[23:16], data[31:24]};
                        crc      <= CRC_INIT;
                        bit_cnt  <= '0;
                        spi_ss   <= 1'b0;
                        busy     <= 1'b1;
                        spi_mosi <= cmd[7];
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    div_cnt <= div_end ? '0 : div_cnt + DW'(1);
                    if (div_end) state <= S_SHIFT;
                end
                S_SHIFT: begin
                    div_cnt <= div_end ? '0 : div_cnt + DW'(1);
                    if (div_end) begin
                        if (!spi_sck) begin
                            // Rising edge: the bit on MOSI is committed, fold it into the CRC.
                            spi_sck <= 1'b1;
                            if (bit_cnt < 6'd48) crc <= crc_step(crc, spi_mosi);
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt == 6'd55) begin
                                spi_mosi <= 1'b0;
                                state    <= S_HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + 6'd1;
                                tx_sreg  <= tx_shifted;
                                spi_mosi <= tx_shifted[47];
                            end
                        end
                    end
                end
                S_HOLD: begin
                    div_cnt <= div_end ? '0 : div_cnt + DW'(1);
                    if (div_end) begin
                        spi_ss <= 1'b1;
                        done   <= 1'b1;
                        tx_crc <= crc;
                        state  <= S_GAP;
                    end
                end
                S_GAP: begin
                    div_cnt <= div_end ? '0 : div_cnt + DW'(1);
                    if (div_end) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HWAG_SPI_MASTER_MISO_CAPTURE_EN
    logic [55:0] rx_sreg;
    logic [7:0]  rx_crc_calc;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sreg     <= '0;
            rx_crc_calc <= '0;
            rx_frame    <= '0;
            rx_crc_ok   <= 1'b0;
        end else begin
            if (state == S_IDLE && start) rx_crc_calc <= CRC_INIT;
            if (sck_rise) begin
                rx_sreg <= {rx_sreg[54:0], spi_miso};
                if (bit_cnt < 6'd48) rx_crc_calc <= crc_step(rx_crc_calc, spi_miso);
            end
            if (hold_end) begin
                // First byte on the wire sits at the top of the shift register.
                for (int j = 0; j < 7; j++) begin
                    rx_frame[8*j +: 8] <= rx_sreg[55-8*j -: 8];
                end
                rx_crc_ok <= (rx_sreg[7:0] == rx_crc_calc);
            end
        end
    end
`else
    logic unused_rx;
    assign unused_rx = spi_miso ^ sck_rise ^ hold_end;
    assign rx_frame  = '0;
    assign rx_crc_ok = 1'b0;
`endif

endmodule

// File: tb/tb_hwag_spi_frame_master.sv
// tb/tb_hwag_spi_frame_master.sv - scoreboard bench for hwag_spi_frame_master
module tb_hwag_spi_frame_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic [7:0]  tx_crc;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_ss;
    logic [55:0] rx_frame;
    logic        rx_crc_ok;

    int checks = 0;
    int errors = 0;
    int flip_idx = -1;
    int sck_edges = 0;
    int done_count = 0;
    logic b2b_mode = 1'b0;

    wire spi_miso = spi_mosi ^ (flip_idx == sck_edges);

    typedef struct {
        logic [55:0] wire_bits;
        logic [7:0]  crc;
        int          flip;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    hwag_spi_frame_master dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .addr(addr), .data(data),
        .busy(busy), .done(done), .tx_crc(tx_crc), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ss(spi_ss),
        .rx_frame(rx_frame), .rx_crc_ok(rx_crc_ok)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] crc8_model(input logic [47:0] bits);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 47; i >= 0; i--) begin
            c = (c[7] ^ bits[i]) ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [47:0] wire48(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d);
        return {c, a, d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [55:0] to_lanes(input logic [55:0] w);
        logic [55:0] r;
        for (int j = 0; j < 7; j++) r[8*j +: 8] = w[55-8*j -: 8];
        return r;
    endfunction

    // Monitor: samples on the falling clk edge, pops the scoreboard at each done.
    initial begin : monitor
        logic [55:0] cap, rx_w;
        logic prev_sck, prev_mosi, prev_done, prev_busy, prev_ss, mode_err, skip_busy, gap_armed, ok;
        int busy_run, ss_low, ss_high;
        exp_t e;
        cap = '0; prev_sck = 0; prev_mosi = 0; prev_done = 0; prev_busy = 0; prev_ss = 1;
        mode_err = 0; skip_busy = 0; gap_armed = 0; busy_run = 0; ss_low = 0; ss_high = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                skip_busy = skip_busy || prev_busy || (busy === 1'b1);
                cap = '0; sck_edges = 0; busy_run = 0; ss_low = 0; ss_high = 0;
                mode_err = 0; gap_armed = 0; prev_sck = 0; prev_done = 0; prev_ss = 1;
                continue;
            end
            if (spi_sck && !prev_sck) begin
                cap = {cap[54:0], spi_mosi};
                sck_edges++;
            end
            if (spi_sck && prev_sck && (spi_mosi !== prev_mosi)) mode_err = 1;
            if (!spi_ss) ss_low++;
            if (spi_ss) ss_high++;
            else begin
                if (prev_ss && gap_armed) chk("ss_gap_cycles", ss_high, 5);
                gap_armed = 0;
                ss_high = 0;
            end
            if (prev_done) chk("done_one_cycle", done, 0);
            if (done) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_bits", cap, e.wire_bits);
                    chk("sck_rising_edges", sck_edges, 56);
                    chk("tx_crc", tx_crc, e.crc);
                    chk("ss_low_cycles", ss_low, 456);
                    chk("mosi_stable_sck_high", mode_err, 0);
                    chk("ss_high_at_done", spi_ss, 1);
`ifdef HWAG_SPI_MASTER_MISO_CAPTURE_EN
                    rx_w = e.wire_bits;
                    if (e.flip >= 0) rx_w[55-e.flip] = ~rx_w[55-e.flip];
                    ok = (crc8_model(rx_w[55:8]) == rx_w[7:0]);
                    chk("rx_frame", rx_frame, to_lanes(rx_w));
                    chk("rx_crc_ok", rx_crc_ok, ok);
`else
                    chk("rx_frame_zero", rx_frame, 0);
                    chk("rx_crc_ok_zero", rx_crc_ok, 0);
`endif
                end
                cap = '0; sck_edges = 0; mode_err = 0; ss_low = 0; ss_high = 1;
                gap_armed = b2b_mode;
            end
            if (busy) busy_run++;
            else if (prev_busy) begin
                if (skip_busy) skip_busy = 0;
                else chk("busy_cycles", busy_run, 460);
                busy_run = 0;
            end
            prev_sck = spi_sck; prev_mosi = spi_mosi; prev_done = done;
            prev_busy = busy; prev_ss = spi_ss;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_not_busy(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin tick(); n++; end
        if (n >= 1000) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 2000) begin tick(); n++; end
        if (n >= 2000) chk({name, "_timeout"}, 1, 0);
        tick();
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d,
                        input logic [7:0] crc, input int flip);
        exp_t e;
        wait_not_busy("send_idle");
        e.wire_bits = {wire48(c, a, d), crc};
        e.crc = crc;
        e.flip = flip;
        exp_q.push_back(e);
        flip_idx = flip;
        cmd = c; addr = a; data = d; start = 1;
        tick();
        start = 0;
        cmd = ~c; addr = ~a; data = ~d;
        repeat (100) tick();
        start = 1; cmd = 8'hFF; addr = 8'hEE; data = 32'hCAFEF00D;
        tick();
        start = 0;
        wait_done("send");
        flip_idx = -1;
    endtask

    task automatic reset_idle();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ss", spi_ss, 1);
        chk("rst_sck", spi_sck, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_done", done, 0);
        chk("rst_tx_crc", tx_crc, 0);
        chk("rst_rx_frame", rx_frame, 0);
        chk("rst_rx_crc_ok", rx_crc_ok, 0);
    endtask

    initial begin : stimulus
        logic [7:0]  vc [3];
        logic [7:0]  va [3];
        logic [31:0] vd [3];
        int n, dc;
        rst = 1; start = 0; cmd = 0; addr = 0; data = 0;
        reset_idle();

        send(8'h00, 8'h00, 32'h0100_0000, 8'h07, -1);
        send(8'h00, 8'h00, 32'h0000_0000, 8'h00, -1);
        send(8'h3C, 8'h81, 32'hDEAD_BEEF, crc8_model(wire48(8'h3C, 8'h81, 32'hDEAD_BEEF)), -1);
        reset_idle();

        // Back-to-back frames with start held high, inputs changed mid-frame.
        vc[0] = 8'h11; va[0] = 8'h22; vd[0] = 32'h3344_5566;
        vc[1] = 8'hF0; va[1] = 8'h0F; vd[1] = 32'h8000_0001;
        vc[2] = 8'h5A; va[2] = 8'hC3; vd[2] = 32'h1234_5678;
        b2b_mode = 1;
        cmd = vc[0]; addr = va[0]; data = vd[0]; start = 1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            wait_not_busy("b2b_idle");
            e.wire_bits = {wire48(vc[k], va[k], vd[k]), crc8_model(wire48(vc[k], va[k], vd[k]))};
            e.crc = e.wire_bits[7:0];
            e.flip = -1;
            exp_q.push_back(e);
            n = 0;
            while (busy !== 1'b1 && n < 10) begin tick(); n++; end
            if (n >= 10) chk("b2b_accept_timeout", 1, 0);
            if (k == 2) begin
                start = 0;
                b2b_mode = 0;
            end else begin
                repeat (100) tick();
                cmd = vc[k+1]; addr = va[k+1]; data = vd[k+1];
            end
        end
        wait_done("b2b");

        // Abort a frame at its 20th SCK rising edge.
        cmd = 8'h77; addr = 8'h66; data = 32'h5544_3322; start = 1;
        tick();
        start = 0;
        n = 0;
        while (sck_edges < 20 && n < 1000) begin tick(); n++; end
        if (n >= 1000) chk("abort_edge_timeout", 1, 0);
        dc = done_count;
        rst = 1;
        tick();
        chk("abort_ss", spi_ss, 1);
        chk("abort_sck", spi_sck, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick();
        rst = 0;
        repeat (600) tick();
        chk("abort_no_done", done_count, dc);

        send(8'hA5, 8'h3C, 32'h0F1E_2D4B, crc8_model(wire48(8'hA5, 8'h3C, 32'h0F1E_2D4B)), -1);
        send(8'h00, 8'h00, 32'h0100_0000, 8'h07, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
